// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// counter-width helper used to size the bit counter.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Ceiling log2, never below 1 so a counter always has at least one bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < value) r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder: start/busy/done handshake,
// operands in, registered sum and status flags out.
interface serial_adder_if #(
   parameter int WIDTH = 8
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             parity;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, ovf, parity
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, ovf, parity
   );

endinterface

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder reused every cycle by the serial adder.
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell processes a bit per cycle,
// LSB first, and the finished word plus flags are published on entry to DONE.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   serial_adder_if.slave   bus
);

   localparam int CNT_W = clog2(WIDTH);

   state_t             state, state_nx;
   logic               accept;
   logic               last_bit;

   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [WIDTH-1:0]   res_sh;
   logic [WIDTH-1:0]   res_full;
   logic [CNT_W-1:0]   cnt;
   logic               c_q;

   logic               cell_s;
   logic               cell_co;

   logic [WIDTH-1:0]   sum_q;
   logic               cout_q;
   logic               ovf_q;
   logic               parity_q;

   fa_cell u_cell (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .ci (c_q),
      .s  (cell_s),
      .co (cell_co)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));
   assign res_full = {cell_s, res_sh[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (bus.start) begin
               accept   = 1'b1;
               state_nx = ST_RUN;
            end
         end
         ST_RUN: begin
            if (last_bit) state_nx = ST_DONE;
         end
         ST_DONE: begin
            if (bus.start) begin
               accept   = 1'b1;
               state_nx = ST_RUN;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         cnt      <= '0;
         c_q      <= 1'b0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         parity_q <= 1'b0;
      end else if (accept) begin
         a_sh <= bus.a;
         b_sh <= bus.b;
         c_q  <= bus.cin;
         cnt  <= '0;
      end else if (state == ST_RUN) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         c_q    <= cell_co;
         res_sh <= res_full;
         cnt    <= cnt + CNT_W'(1);
         // On the MSB cycle c_q is exactly the carry into the MSB.
         if (last_bit) begin
            sum_q    <= res_full;
            cout_q   <= cell_co;
            ovf_q    <= c_q ^ cell_co;
            parity_q <= ^res_full;
         end
      end
   end

   assign bus.busy   = (state == ST_RUN);
   assign bus.done   = (state == ST_DONE);
   assign bus.sum    = sum_q;
   assign bus.cout   = cout_q;
   assign bus.ovf    = ovf_q;
   assign bus.parity = parity_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): hand-computed vectors, handshake
// timing, start-during-RUN, mid-operation reset and back-to-back streaming.
module tb_serial_adder;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   serial_adder_if #(.WIDTH(8)) bus ();

   serial_adder #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [7:0] s, input logic co,
                          input logic ov, input logic par);
      chk({tag, "_sum"},    {24'd0, bus.sum}, {24'd0, s});
      chk({tag, "_cout"},   {31'd0, bus.cout}, {31'd0, co});
      chk({tag, "_ovf"},    {31'd0, bus.ovf}, {31'd0, ov});
      chk({tag, "_parity"}, {31'd0, bus.parity}, {31'd0, par});
   endtask

   // Issue one operation from IDLE and wait (bounded) for its done pulse.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         input string tag);
      int         lat;
      int         bcnt;
      logic       hold_ok;
      logic [7:0] hold;
      hold    = bus.sum;
      hold_ok = 1'b1;
      bus.a = ta; bus.b = tb_v; bus.cin = tc; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      lat  = 0;
      bcnt = 0;
      while (!bus.done && lat < 20) begin
         if (bus.busy) bcnt++;
         if (bus.sum !== hold) hold_ok = 1'b0;
         step();
         lat++;
      end
      chk({tag, "_latency"}, lat, 8);
      chk({tag, "_busy_cycles"}, bcnt, 8);
      chk({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
      chk({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      int prev;
      int npulse;
      int ndone;
      total = 0;
      bad   = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_done", {31'd0, bus.done}, 32'd0);
      chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);

      // 1: zero + zero
      run_op(8'h00, 8'h00, 1'b0, "t1");
      chk_out("t1", 8'h00, 1'b0, 1'b0, 1'b0);
      step();
      chk("t1_done_drop", {31'd0, bus.done}, 32'd0);

      // 2: unsigned wrap, carry out
      run_op(8'hFF, 8'h01, 1'b0, "t2");
      chk_out("t2", 8'h00, 1'b1, 1'b0, 1'b0);
      step();

      // 4: start pulsed and operands changed in the middle of RUN
      bus.a = 8'hA5; bus.b = 8'h5A; bus.cin = 1'b1; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      ndone = 0;
      for (int i = 1; i <= 12; i++) begin
         if (i == 4) begin
            bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b0; bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         step();
         if (bus.done) begin
            ndone++;
            chk("t4_done_edge", i, 8);
            chk_out("t4", 8'h00, 1'b1, 1'b0, 1'b0);
         end
      end
      bus.start = 1'b0;
      chk("t4_done_count", ndone, 1);

      // 3: signed overflow
      run_op(8'h7F, 8'h01, 1'b0, "t3");
      chk_out("t3", 8'h80, 1'b0, 1'b1, 1'b1);
      step();

      // 5: reset after the 4th RUN edge aborts the operation
      bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("t5_hold_sum", {24'd0, bus.sum}, 32'h80);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_busy", {31'd0, bus.busy}, 32'd0);
      chk("t5_done", {31'd0, bus.done}, 32'd0);
      chk_out("t5", 8'h00, 1'b0, 1'b0, 1'b0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.done) ndone++;
      end
      chk("t5_no_done", ndone, 0);

      // 6: start held high, back-to-back operations
      bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0; bus.start = 1'b1;
      step();
      prev   = -1;
      npulse = 0;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (bus.done) begin
            npulse++;
            chk("t6_sum", {24'd0, bus.sum}, 32'h30);
            chk("t6_busy_in_done", {31'd0, bus.busy}, 32'd0);
            if (prev >= 0) chk("t6_spacing", i - prev, 9);
            else           chk("t6_first", i, 8);
            prev = i;
         end else begin
            chk("t6_busy", {31'd0, bus.busy}, 32'd1);
            if (prev >= 0) chk("t6_hold", {24'd0, bus.sum}, 32'h30);
         end
      end
      bus.start = 1'b0;
      chk("t6_pulses", npulse, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
